// File: rtl/ca_pkg.sv
// Shared constants, state encoding and neighbourhood helper for the elementary CA row stepper.
package ca_pkg;

    localparam int CA_W = 80;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } ca_state_t;

    localparam logic [7:0] RULE_30  = 8'd30;
    localparam logic [7:0] RULE_90  = 8'd90;
    localparam logic [7:0] RULE_110 = 8'd110;

    // Wolfram ordering: left neighbour is the MSB of the rule-table index.
    function automatic logic [2:0] nbr_idx(input logic l, input logic c, input logic r);
        return {l, c, r};
    endfunction

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector for the prescaler square wave; zero-latency pulse, no backpressure.
// The history register resets to 1 so a level already high at reset is not taken as an edge.
module tick_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic i_tick,
    output logic o_edge
);

    logic r_tick_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_tick_q <= 1'b1;
        end else begin
            r_tick_q <= i_tick;
        end
    end

    assign o_edge = i_tick & ~r_tick_q;

endmodule

// File: rtl/ca_row_stepper.sv
// Serial elementary-CA generation engine: one cell per clock, W+2 cycles from tick edge to committed row.
// No backpressure; tick edges arriving mid-step are dropped and flagged as a sticky overrun.
module ca_row_stepper
    import ca_pkg::*;
#(
    parameter int W     = CA_W,
    parameter int GEN_W = 16,
    parameter int WRAP  = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick_in,
    input  logic [7:0]       rule,
    input  logic [W-1:0]     seed,
    input  logic             load,
    input  logic             run,
    output logic [W-1:0]     row_out,
    output logic             row_valid,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             overrun
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    logic             w_edge;
    logic             w_l;
    logic             w_c;
    logic             w_r;
    logic             w_new_bit;

    ca_state_t        r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_row;
    logic [W-1:0]     r_next;
    logic [7:0]       r_rule_q;
    logic [GEN_W-1:0] r_gen;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    tick_edge u_tick_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .i_tick (tick_in),
        .o_edge (w_edge)
    );

    // Neighbourhood of the cell being computed; the committed row is read, never the shadow.
    always_comb begin
        w_c = r_row[r_idx];
        w_l = 1'b0;
        w_r = 1'b0;
        if (r_idx == LAST_IDX) begin
            w_l = (WRAP != 0) ? r_row[0] : 1'b0;
        end else begin
            w_l = r_row[r_idx + IDX_W'(1)];
        end
        if (r_idx == '0) begin
            w_r = (WRAP != 0) ? r_row[W-1] : 1'b0;
        end else begin
            w_r = r_row[r_idx - IDX_W'(1)];
        end
        w_new_bit = r_rule_q[nbr_idx(w_l, w_c, w_r)];
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_row     <= '0;
            r_next    <= '0;
            r_rule_q  <= '0;
            r_gen     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (load) begin
                // Load wins over everything, including a same-cycle tick edge.
                r_row     <= seed;
                r_gen     <= '0;
                r_valid   <= 1'b1;
                r_overrun <= 1'b0;
                r_idx     <= '0;
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_edge && run) begin
                            r_rule_q <= rule;
                            r_idx    <= '0;
                            r_state  <= ST_COMPUTE;
                            r_busy   <= 1'b1;
                        end
                    end
                    ST_COMPUTE: begin
                        if (w_edge) begin
                            r_overrun <= 1'b1;
                        end
                        r_next[r_idx] <= w_new_bit;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                    ST_COMMIT: begin
                        if (w_edge) begin
                            r_overrun <= 1'b1;
                        end
                        r_row   <= r_next;
                        r_gen   <= r_gen + GEN_W'(1);
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign row_out   = r_row;
    assign row_valid = r_valid;
    assign busy      = r_busy;
    assign gen_count = r_gen;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_ca_row_stepper.sv
// Directed bench for ca_row_stepper: toroidal, zero-boundary and 4-bit-counter instances share stimulus.
module tb_ca_row_stepper;
    import ca_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        tick_in;
    logic [7:0]  rule;
    logic [79:0] seed;
    logic        load;
    logic        run;

    logic [79:0] row_out,   row_out_nw,   row_out_g4;
    logic        row_valid, row_valid_nw, row_valid_g4;
    logic        busy,      busy_nw,      busy_g4;
    logic [15:0] gen_count, gen_count_nw;
    logic [3:0]  gen_count_g4;
    logic        overrun,   overrun_nw,   overrun_g4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    ca_row_stepper #(.W(80), .GEN_W(16), .WRAP(1)) dut (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .rule(rule), .seed(seed),
        .load(load), .run(run), .row_out(row_out), .row_valid(row_valid),
        .busy(busy), .gen_count(gen_count), .overrun(overrun)
    );

    ca_row_stepper #(.W(80), .GEN_W(16), .WRAP(0)) dut_nw (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .rule(rule), .seed(seed),
        .load(load), .run(run), .row_out(row_out_nw), .row_valid(row_valid_nw),
        .busy(busy_nw), .gen_count(gen_count_nw), .overrun(overrun_nw)
    );

    ca_row_stepper #(.W(80), .GEN_W(4), .WRAP(1)) dut_g4 (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .rule(rule), .seed(seed),
        .load(load), .run(run), .row_out(row_out_g4), .row_valid(row_valid_g4),
        .busy(busy_g4), .gen_count(gen_count_g4), .overrun(overrun_g4)
    );

    typedef struct {
        string       name;
        logic [79:0] seed;
        logic [7:0]  rl;
        logic [79:0] exp_wrap;
        logic [79:0] exp_nowrap;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [79:0] b(input int i);
        logic [79:0] one;
        one = 80'd1;
        return one << i;
    endfunction

    // Rule 30 written as L xor (C or R), toroidal.
    function automatic logic [79:0] rule30_next(input logic [79:0] r);
        logic [79:0] lv;
        logic [79:0] rv;
        lv = {r[0], r[79:1]};
        rv = {r[78:0], r[79]};
        return lv ^ (r | rv);
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input logic [79:0] s);
        seed = s;
        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("load_row", row_out, s);
        chk("load_valid", 80'(row_valid), 80'd1);
        chk("load_gen0", 80'(gen_count), 80'd0);
        chk("load_ovr0", 80'(overrun), 80'd0);
    endtask

    // Raise tick, follow the full step window, then drop tick.
    task automatic run_step(input logic [7:0] r);
        bit ok;
        ok = 1'b1;
        rule = r;
        tick_in = 1'b1;
        for (int k = 1; k <= 83; k++) begin
            cyc();
            if (busy !== (k <= 81)) ok = 1'b0;
            if (row_valid !== (k == 82)) ok = 1'b0;
        end
        tick_in = 1'b0;
        cyc();
        chk("step_timing", 80'(ok), 80'd1);
    endtask

    initial begin
        logic [79:0] model;
        logic [79:0] pat;
        int          pulses;
        bit          saw_busy;

        vecs[0] = '{"r90_mid",   b(40), RULE_90,   b(39) | b(41),       b(39) | b(41)};
        vecs[1] = '{"r90_b0",    b(0),  RULE_90,   b(1) | b(79),        b(1)};
        vecs[2] = '{"r90_b79",   b(79), RULE_90,   b(78) | b(0),        b(78)};
        vecs[3] = '{"r30_mid",   b(40), RULE_30,   b(39) | b(40) | b(41), b(39) | b(40) | b(41)};
        vecs[4] = '{"r1_zero",   80'd0, 8'd1,      ~80'd0,              ~80'd0};
        vecs[5] = '{"r110_ones", ~80'd0, RULE_110, 80'd0,               b(0) | b(79)};
        vecs[6] = '{"r240_left", b(79) | b(0), 8'd240, b(79) | b(78),  b(78)};
        vecs[7] = '{"r170_right", b(79) | b(0), 8'd170, b(1) | b(0),   b(1)};
        vecs[8] = '{"r204_ident", 80'hDEAD_BEEF_0123_4567_89AB, 8'd204,
                    80'hDEAD_BEEF_0123_4567_89AB, 80'hDEAD_BEEF_0123_4567_89AB};

        rst = 1'b1; tick_in = 1'b1; rule = 8'd0; seed = '0; load = 1'b0; run = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_row", row_out | row_out_nw | row_out_g4, 80'd0);
        chk("rst_valid", 80'(row_valid | row_valid_nw | row_valid_g4), 80'd0);
        chk("rst_busy", 80'(busy | busy_nw | busy_g4), 80'd0);
        chk("rst_gen", 80'(gen_count) | 80'(gen_count_nw) | 80'(gen_count_g4), 80'd0);
        chk("rst_ovr", 80'(overrun | overrun_nw | overrun_g4), 80'd0);

        // Tick held high through reset must not start a step.
        saw_busy = 1'b0;
        for (int k = 0; k < 90; k++) begin
            cyc();
            if (busy) saw_busy = 1'b1;
        end
        chk("tick_high_rst_busy", 80'(saw_busy), 80'd0);
        chk("tick_high_rst_gen", 80'(gen_count), 80'd0);
        tick_in = 1'b0;
        cyc();

        for (int v = 0; v < 9; v++) begin
            do_load(vecs[v].seed);
            run_step(vecs[v].rl);
            chk({vecs[v].name, "_wrap"}, row_out, vecs[v].exp_wrap);
            chk({vecs[v].name, "_nowrap"}, row_out_nw, vecs[v].exp_nowrap);
            chk({vecs[v].name, "_gen"}, 80'(gen_count), 80'd1);
        end

        // Three rule-30 generations against the reference model.
        do_load(b(40));
        model = b(40);
        for (int s = 0; s < 3; s++) begin
            run_step(RULE_30);
            model = rule30_next(model);
            chk("r30_multi", row_out, model);
        end
        chk("r30_gen3", 80'(gen_count), 80'd3);

        // Paused: edges ignored, no overrun.
        run = 1'b0;
        saw_busy = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick_in = 1'b1;
            for (int k = 0; k < 10; k++) begin cyc(); if (busy) saw_busy = 1'b1; end
            tick_in = 1'b0;
            for (int k = 0; k < 10; k++) begin cyc(); if (busy) saw_busy = 1'b1; end
        end
        chk("pause_busy", 80'(saw_busy), 80'd0);
        chk("pause_ovr", 80'(overrun), 80'd0);
        chk("pause_row", row_out, model);
        chk("pause_gen", 80'(gen_count), 80'd3);
        run = 1'b1;

        // Second edge 10 cycles after the first.
        do_load(b(40));
        rule = RULE_90;
        tick_in = 1'b1;
        repeat (5) cyc();
        tick_in = 1'b0;
        repeat (5) cyc();
        tick_in = 1'b1;
        cyc();
        chk("ovr_set", 80'(overrun), 80'd1);
        pulses = 0;
        for (int k = 0; k < 120; k++) begin
            cyc();
            if (row_valid) pulses++;
        end
        tick_in = 1'b0;
        cyc();
        chk("ovr_one_commit", 80'(pulses), 80'd1);
        chk("ovr_gen", 80'(gen_count), 80'd1);
        chk("ovr_row", row_out, b(39) | b(41));
        chk("ovr_sticky", 80'(overrun), 80'd1);
        do_load(b(10));

        // Load at T+40 aborts the step.
        do_load(b(40));
        pat = 80'h1234_5678_9ABC_DEF0_5A5A;
        rule = RULE_90;
        tick_in = 1'b1;
        repeat (40) cyc();
        chk("abort_busy_before", 80'(busy), 80'd1);
        seed = pat;
        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("abort_row", row_out, pat);
        chk("abort_valid", 80'(row_valid), 80'd1);
        chk("abort_busy", 80'(busy), 80'd0);
        pulses = 0;
        saw_busy = 1'b0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (row_valid) pulses++;
            if (busy) saw_busy = 1'b1;
        end
        chk("abort_no_commit", 80'(pulses), 80'd0);
        chk("abort_no_busy", 80'(saw_busy), 80'd0);
        chk("abort_gen", 80'(gen_count), 80'd0);
        chk("abort_row_hold", row_out, pat);
        tick_in = 1'b0;
        cyc();

        // Reset mid-compute.
        tick_in = 1'b1;
        repeat (20) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_row", row_out, 80'd0);
        chk("mid_rst_flags", 80'({row_valid, busy, overrun}), 80'd0);
        chk("mid_rst_gen", 80'(gen_count), 80'd0);
        pulses = 0;
        for (int k = 0; k < 90; k++) begin
            cyc();
            if (row_valid || busy) pulses++;
        end
        chk("mid_rst_no_commit", 80'(pulses), 80'd0);
        tick_in = 1'b0;
        cyc();

        // 4-bit generation counter wraps after 16 steps.
        do_load(b(40));
        for (int s = 0; s < 15; s++) run_step(RULE_90);
        chk("g4_gen15", 80'(gen_count_g4), 80'd15);
        run_step(RULE_90);
        chk("g4_wrap", 80'(gen_count_g4), 80'd0);
        chk("g16_gen16", 80'(gen_count), 80'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
